// File: rtl/car_dispatcher.sv
// Two-car elevator call dispatcher: captures one-hot hall calls into a pending
// bitmap and assigns the lowest pending floor to the nearest idle car.
module car_dispatcher #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       call_valid,
    input  logic [3:0] call_floor,
    input  logic [3:0] carA_floor,
    input  logic [3:0] carB_floor,
    input  logic       carA_idle,
    input  logic       carB_idle,
    input  logic       carA_ack,
    input  logic       carB_ack,
    output logic       carA_go,
    output logic [3:0] carA_des,
    output logic       carB_go,
    output logic [3:0] carB_des,
    output logic [3:0] pending,
    output logic       call_err,
    output logic [1:0] dbg_state,
    output logic       dbg_rr_b
);

    localparam int CNT_W = ($clog2(ACK_TIMEOUT + 1) > 4) ? $clog2(ACK_TIMEOUT + 1) : 4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_ISSUE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       target_q, target_d;
    logic             sel_b_q, sel_b_d;
    logic             rr_b_q, rr_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic       onehot, issuing, ack_sel, blocked;
    logic [3:0] cap_mask, clr_mask, pick;
    logic [1:0] dist_a, dist_b;

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        if (oh[0])      r = 2'd0;
        else if (oh[1]) r = 2'd1;
        else if (oh[2]) r = 2'd2;
        else if (oh[3]) r = 2'd3;
        return r;
    endfunction

    function automatic logic [1:0] absdiff(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        onehot   = (call_floor != 4'd0) && ((call_floor & (call_floor - 4'd1)) == 4'd0);
        issuing  = (state_q == S_ISSUE);
        ack_sel  = issuing && (sel_b_q ? carB_ack : carA_ack);
        blocked  = (issuing && (call_floor == target_q))
                 || (carA_idle && (call_floor == carA_floor))
                 || (carB_idle && (call_floor == carB_floor));
        cap_mask = (call_valid && onehot && !blocked) ? call_floor : 4'd0;
        clr_mask = ack_sel ? target_q : 4'd0;
        // Clear is applied after capture so an ack always wins over a same-cycle call.
        pending_d = (pending_q | cap_mask) & ~clr_mask;
        err_d     = call_valid && !onehot && (pending_q != 4'hF);

        pick   = pending_q & (~pending_q + 4'd1);
        dist_a = absdiff(idx_of(carA_floor), idx_of(pick));
        dist_b = absdiff(idx_of(carB_floor), idx_of(pick));

        state_d  = state_q;
        target_d = target_q;
        sel_b_d  = sel_b_q;
        rr_b_d   = rr_b_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if ((pending_q != 4'd0) && (carA_idle || carB_idle))
                    state_d = S_SELECT;
            end
            S_SELECT: begin
                if ((!carA_idle && !carB_idle) || (pending_q == 4'd0)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_ISSUE;
                    target_d = pick;
                    cnt_d    = '0;
                    if (!carB_idle)          sel_b_d = 1'b0;
                    else if (!carA_idle)     sel_b_d = 1'b1;
                    else if (dist_a < dist_b) sel_b_d = 1'b0;
                    else if (dist_b < dist_a) sel_b_d = 1'b1;
                    else begin
                        sel_b_d = rr_b_q;
                        rr_b_d  = !rr_b_q;
                    end
                end
            end
            S_ISSUE: begin
                if (ack_sel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abandoned car loses its turn; the call stays pending.
                    state_d = S_IDLE;
                    rr_b_d  = !sel_b_q;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= 4'd0;
            target_q  <= 4'hF;
            sel_b_q   <= 1'b0;
            rr_b_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            target_q  <= target_d;
            sel_b_q   <= sel_b_d;
            rr_b_q    <= rr_b_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign carA_go   = issuing && !sel_b_q;
    assign carB_go   = issuing && sel_b_q;
    assign carA_des  = carA_go ? target_q : 4'hF;
    assign carB_des  = carB_go ? target_q : 4'hF;
    assign pending   = pending_q;
    assign call_err  = err_q;
    assign dbg_state = state_q;
    assign dbg_rr_b  = rr_b_q;

endmodule

// File: tb/tb_car_dispatcher.sv
// Directed bench for car_dispatcher: a cycle-by-cycle vector table plus
// hand-written timeout and reset-during-issue sequences.
module tb_car_dispatcher;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       call_valid;
    logic [3:0] call_floor, carA_floor, carB_floor;
    logic       carA_idle, carB_idle, carA_ack, carB_ack;
    logic       carA_go, carB_go, call_err, dbg_rr_b;
    logic [3:0] carA_des, carB_des, pending;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    car_dispatcher #(.ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .call_valid (call_valid),
        .call_floor (call_floor),
        .carA_floor (carA_floor),
        .carB_floor (carB_floor),
        .carA_idle  (carA_idle),
        .carB_idle  (carB_idle),
        .carA_ack   (carA_ack),
        .carB_ack   (carB_ack),
        .carA_go    (carA_go),
        .carA_des   (carA_des),
        .carB_go    (carB_go),
        .carB_des   (carB_des),
        .pending    (pending),
        .call_err   (call_err),
        .dbg_state  (dbg_state),
        .dbg_rr_b   (dbg_rr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [3:0] cf, af, bf;
        logic       ai, bi, aa, ba;
        logic       ga;
        logic [3:0] da;
        logic       gb;
        logic [3:0] db, pend;
        logic       err;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic cv, input logic [3:0] cf, input logic [3:0] af,
                       input logic [3:0] bf, input logic ai, input logic bi,
                       input logic aa, input logic ba, input logic ga, input logic [3:0] da,
                       input logic gb, input logic [3:0] db, input logic [3:0] pend,
                       input logic err, input logic [1:0] st);
        vec_t v;
        v.cv = cv; v.cf = cf; v.af = af; v.bf = bf;
        v.ai = ai; v.bi = bi; v.aa = aa; v.ba = ba;
        v.ga = ga; v.da = da; v.gb = gb; v.db = db;
        v.pend = pend; v.err = err; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic cv, input logic [3:0] cf, input logic [3:0] af,
                          input logic [3:0] bf, input logic ai, input logic bi,
                          input logic aa, input logic ba);
        call_valid = cv; call_floor = cf; carA_floor = af; carB_floor = bf;
        carA_idle = ai; carB_idle = bi; carA_ack = aa; carB_ack = ba;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 4'd0, 4'b0001, 4'b1000, 0, 0, 0, 0);
        #1;
        chk("rst carA_go",  carA_go,  0);
        chk("rst carB_go",  carB_go,  0);
        chk("rst carA_des", carA_des, 4'hF);
        chk("rst carB_des", carB_des, 4'hF);
        chk("rst pending",  pending,  0);
        chk("rst call_err", call_err, 0);
        chk("rst state",    dbg_state, 0);
        chk("rst rr",       dbg_rr_b, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // A at floor 1, B at floor 4: call floor 3 goes to B (closer); wrong-car ack ignored.
        add(1, 4'b0100, 4'b0001, 4'b1000, 1, 1, 0, 0, 0, 4'hF, 0, 4'hF,    4'b0100, 0, 0);
        add(0, 4'b0000, 4'b0001, 4'b1000, 1, 1, 0, 0, 0, 4'hF, 0, 4'hF,    4'b0100, 0, 1);
        add(0, 4'b0000, 4'b0001, 4'b1000, 1, 1, 0, 0, 0, 4'hF, 1, 4'b0100, 4'b0100, 0, 2);
        add(0, 4'b0000, 4'b0001, 4'b1000, 1, 1, 1, 0, 0, 4'hF, 1, 4'b0100, 4'b0100, 0, 2);
        add(0, 4'b0000, 4'b0001, 4'b1000, 1, 1, 0, 1, 0, 4'hF, 0, 4'hF,    4'b0000, 0, 0);
        // Both at floor 1: tied calls alternate A then B.
        add(1, 4'b0010, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    0, 4'hF,    4'b0010, 0, 0);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    0, 4'hF,    4'b0010, 0, 1);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 1, 4'b0010, 0, 4'hF,    4'b0010, 0, 2);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 1, 0, 0, 4'hF,    0, 4'hF,    4'b0000, 0, 0);
        add(1, 4'b0100, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    0, 4'hF,    4'b0100, 0, 0);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    0, 4'hF,    4'b0100, 0, 1);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    1, 4'b0100, 4'b0100, 0, 2);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 1, 0, 4'hF,    0, 4'hF,    4'b0000, 0, 0);
        // Malformed calls: error pulse for one cycle, nothing captured.
        add(1, 4'b0011, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF, 0, 4'hF, 4'b0000, 1, 0);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF, 0, 4'hF, 4'b0000, 0, 0);
        add(1, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF, 0, 4'hF, 4'b0000, 1, 0);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF, 0, 4'hF, 4'b0000, 0, 0);
        // Capture during issue, ack racing a call to the same floor, then rr goes to B.
        add(1, 4'b1000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    0, 4'hF,    4'b1000, 0, 0);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    0, 4'hF,    4'b1000, 0, 1);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 1, 4'b1000, 0, 4'hF,    4'b1000, 0, 2);
        add(1, 4'b0010, 4'b0001, 4'b0001, 1, 1, 0, 0, 1, 4'b1000, 0, 4'hF,    4'b1010, 0, 2);
        add(1, 4'b1000, 4'b0001, 4'b0001, 1, 1, 1, 0, 0, 4'hF,    0, 4'hF,    4'b0010, 0, 0);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    0, 4'hF,    4'b0010, 0, 1);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    1, 4'b0010, 4'b0010, 0, 2);
        add(0, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 1, 0, 4'hF,    0, 4'hF,    4'b0000, 0, 0);
        add(1, 4'b0001, 4'b0001, 4'b0001, 1, 1, 0, 0, 0, 4'hF,    0, 4'hF,    4'b0000, 0, 0);
        // No idle car: fill pending, then further calls (even malformed) do nothing.
        add(1, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 4'hF, 0, 4'hF, 4'b0001, 0, 0);
        add(1, 4'b0010, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 4'hF, 0, 4'hF, 4'b0011, 0, 0);
        add(1, 4'b0100, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 4'hF, 0, 4'hF, 4'b0111, 0, 0);
        add(1, 4'b1000, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 4'hF, 0, 4'hF, 4'b1111, 0, 0);
        add(1, 4'b0011, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 4'hF, 0, 4'hF, 4'b1111, 0, 0);
        add(1, 4'b0010, 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 4'hF, 0, 4'hF, 4'b1111, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].cv, vecs[i].cf, vecs[i].af, vecs[i].bf,
                   vecs[i].ai, vecs[i].bi, vecs[i].aa, vecs[i].ba);
            step();
            chk($sformatf("v%0d carA_go", i),  carA_go,   vecs[i].ga);
            chk($sformatf("v%0d carA_des", i), carA_des,  vecs[i].da);
            chk($sformatf("v%0d carB_go", i),  carB_go,   vecs[i].gb);
            chk($sformatf("v%0d carB_des", i), carB_des,  vecs[i].db);
            chk($sformatf("v%0d pending", i),  pending,   vecs[i].pend);
            chk($sformatf("v%0d call_err", i), call_err,  vecs[i].err);
            chk($sformatf("v%0d state", i),    dbg_state, vecs[i].st);
        end

        // Timeout: only A idle, call floor 4, A never acks.
        set_in(0, 4'd0, 4'b0001, 4'b0001, 0, 0, 0, 0);
        do_reset();
        set_in(1, 4'b1000, 4'b0001, 4'b0001, 1, 0, 0, 0);
        step();
        set_in(0, 4'd0, 4'b0001, 4'b0001, 1, 0, 0, 0);
        step();
        step();
        chk("to go first cycle", carA_go, 1);
        chk("to des", carA_des, 4'b1000);
        carA_idle = 1'b0;
        for (int k = 1; k < TO; k++) begin
            step();
            chk($sformatf("to go cycle %0d", k + 1), carA_go, 1);
        end
        step();
        chk("to go dropped", carA_go, 0);
        chk("to des released", carA_des, 4'hF);
        chk("to pending kept", pending, 4'b1000);
        chk("to rr to B", dbg_rr_b, 1);
        chk("to state idle", dbg_state, 0);
        // Tied both-idle reselect must now favour B.
        set_in(0, 4'd0, 4'b0001, 4'b0001, 1, 1, 0, 0);
        step();
        step();
        chk("to reselect B go", carB_go, 1);
        chk("to reselect B des", carB_des, 4'b1000);
        chk("to reselect A go", carA_go, 0);
        carB_ack = 1'b1;
        step();
        carB_ack = 1'b0;
        chk("to reselect cleared", pending, 4'b0000);

        // Reset while issuing with pending = 0110.
        set_in(1, 4'b0010, 4'b0001, 4'b0001, 0, 0, 0, 0);
        step();
        call_floor = 4'b0100;
        step();
        set_in(0, 4'd0, 4'b0001, 4'b0001, 1, 0, 0, 0);
        step();
        step();
        chk("mid pending", pending, 4'b0110);
        chk("mid carA_go", carA_go, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async carA_go", carA_go, 0);
        chk("async carA_des", carA_des, 4'hF);
        chk("async pending", pending, 0);
        chk("async state", dbg_state, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("post rst carA_go %0d", k), carA_go, 0);
            chk($sformatf("post rst carB_go %0d", k), carB_go, 0);
            chk($sformatf("post rst pending %0d", k), pending, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/car_dispatcher.md
CAR_DISPATCHER -- requirements
Module: car_dispatcher

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: cycles ISSUE waits for a car ack before abandoning.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 call_valid  input  1  single-cycle strobe; call_floor valid this cycle.
REQ-005 call_floor  input  4  requested floor, one-hot (bit0 = floor 1).
REQ-006 carA_floor  input  4  car A current floor, one-hot.
REQ-007 carB_floor  input  4  car B current floor, one-hot.
REQ-008 carA_idle  input  1  car A stationary with empty queue; eligible for assignment.
REQ-009 carB_idle  input  1  car B equivalent.
REQ-010 carA_ack  input  1  car A accepted carA_des.
REQ-011 carB_ack  input  1  car B accepted carB_des.
REQ-012 carA_go  output  1  assignment request to car A.
REQ-013 carA_des  output  4  destination for car A; 4'b1111 when no assignment.
REQ-014 carB_go  output  1  assignment request to car B.
REQ-015 carB_des  output  4  car B equivalent.
REQ-016 pending  output  4  bitmap of captured, unassigned calls.
REQ-017 call_err  output  1  one-cycle pulse: call_valid with non-one-hot call_floor.

Function
REQ-018 Capture: call_valid with one-hot call_floor sets the matching pending bit at the next edge. The bit is not set if it is already pending, equals the destination currently being issued, or equals the floor of an idle car.
REQ-019 call_valid with zero or multiple bits set is ignored; call_err pulses high for exactly the next cycle.
REQ-020 FSM states: IDLE, SELECT, ISSUE; one state per cycle except ISSUE.
REQ-021 IDLE -> SELECT when pending != 0 and (carA_idle or carB_idle); otherwise remain in IDLE.
REQ-022 SELECT target call: the lowest-index set pending bit, latched at the SELECT edge.
REQ-023 SELECT target car: the single idle car if only one is idle. If both are idle, the car with the smaller |floor index difference| to the target. On a tie, the car named by the round-robin pointer, and the pointer toggles.
REQ-024 If no car is idle at SELECT, return to IDLE with no output change.
REQ-025 ISSUE: chosen car's go = 1 and des = target from the cycle after SELECT; des is stable while go is high; the other car's go = 0 and des = 4'b1111.
REQ-026 ISSUE, ack from chosen car: at that edge, clear the target pending bit, drop go, set des to 4'b1111, go to IDLE.
REQ-027 Ack from the non-chosen car, or any ack outside ISSUE, is ignored.
REQ-028 ISSUE timeout: ACK_TIMEOUT cycles without ack -> drop go, keep the pending bit, force the round-robin pointer to the other car, go to IDLE.
REQ-029 Latency: call captured at edge n with a car idle -> go high after edge n+2; minimum call-to-ack-clear is 4 cycles.
REQ-030 Simultaneous capture and clear of the same floor in one cycle: the clear wins, and the bit ends at 0.
REQ-031 Simultaneous captures of other floors during ISSUE are accepted normally.
REQ-032 pending full (4'b1111): further valid calls have no effect and raise no error.
REQ-033 The timeout counter is 4 bits minimum, saturates, and resets on ISSUE entry.

Reset
REQ-034 While reset is high: carA_go = carB_go = 0, carA_des = carB_des = 4'b1111, pending = 0, call_err = 0, FSM = IDLE, round-robin pointer = car A, timeout counter = 0.
REQ-035 Reset asserted during ISSUE drops go asynchronously; no pending state survives reset.

Verification
REQ-036 Both cars idle, A at 0001, B at 1000, call 0100 -> carB_go high two cycles later, carB_des = 0100; carB_ack -> pending = 0000, carB_des = 1111.
REQ-037 Both cars idle at 0001, two sequential tied calls 0010 then 0100 -> first assigned to A, second to B.
REQ-038 Call 0011 -> call_err pulse for one cycle, pending unchanged at 0000.
REQ-039 Only A idle, call 1000, no ack for ACK_TIMEOUT cycles -> carA_go drops, pending = 1000, round-robin pointer = B.
REQ-040 Reset asserted mid-ISSUE with pending = 0110 -> outputs immediately go to reset values; after release, no go for 2 cycles.
REQ-041 Capture of the floor being acked in the same cycle -> that pending bit reads 0 afterward.
